ysyx_22040632_div_ctrl: RTL and testbench

YSYX_22040632_DIV_CTRL -- requirements
Module: ysyx_22040632_div_ctrl

---
 rtl/ysyx_22040632_riscv_pkg.sv | 21 ++
 rtl/ysyx_22040632_div_step.sv | 28 ++
 rtl/ysyx_22040632_div_ctrl.sv | 150 +++++++++++++++
 tb/tb_ysyx_22040632_div_ctrl.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/ysyx_22040632_riscv_pkg.sv
// rtl/ysyx_22040632_riscv_pkg.sv - shared divider types, FSM states and iteration counts
package ysyx_22040632_riscv_pkg;

   typedef struct packed {
      logic is_signed;
      logic is_rem;
      logic is_word;
   } div_op_t;

   typedef enum logic [2:0] {
      IDLE,
      PREP,
      CALC,
      FIXUP,
      DONE
   } div_state_e;

   localparam int DIV_N64 = 64;
   localparam int DIV_N32 = 32;

endpackage

// File: rtl/ysyx_22040632_div_step.sv
// rtl/ysyx_22040632_div_step.sv - one restoring shift-subtract step of unsigned division
module ysyx_22040632_div_step #(
   parameter int XLEN = 64
) (
   input  logic [XLEN-1:0] rem,
   input  logic [XLEN-1:0] quo,
   input  logic [XLEN-1:0] divisor,
   output logic [XLEN-1:0] rem_next,
   output logic [XLEN-1:0] quo_next
);

   logic [XLEN:0] wide;
   logic [XLEN:0] diff;

   // The partial remainder stays below the divisor, so one extra bit is enough to see a borrow.
   always_comb begin
      wide = {rem, quo[XLEN-1]};
      diff = wide - {1'b0, divisor};
      if (!diff[XLEN]) begin
         rem_next = diff[XLEN-1:0];
         quo_next = {quo[XLEN-2:0], 1'b1};
      end else begin
         rem_next = wide[XLEN-1:0];
         quo_next = {quo[XLEN-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/ysyx_22040632_div_ctrl.sv
// rtl/ysyx_22040632_div_ctrl.sv - iterative divider controller (IDLE/PREP/CALC/FIXUP/DONE)
// YSYX_22040632_DIV_EARLY_OUT_EN: divide-by-zero and overflow complete straight from PREP.
module ysyx_22040632_div_ctrl
   import ysyx_22040632_riscv_pkg::*;
#(
   parameter int XLEN  = 64,
   parameter int CNT_W = 7
) (
   input  logic            clk,
   input  logic            rrst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  div_op_t         div_op,
   input  logic [XLEN-1:0] src1,
   input  logic [XLEN-1:0] src2,
   output logic            busy,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result
);

   localparam logic [XLEN-1:0] ONES  = '1;
   localparam logic [XLEN-1:0] MIN_D = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [XLEN-1:0] MIN_W = {{(XLEN-31){1'b1}}, 31'b0};
   localparam int              WSH   = XLEN - DIV_N32;

   div_state_e      state;
   div_op_t         op_r;
   logic [XLEN-1:0] a_r, b_r, rem_r, quo_r;
   logic [CNT_W-1:0] cnt;
   logic            q_neg, r_neg, div0_r, ovf_r;

   logic [XLEN-1:0] ext_a, ext_b, abs_a, abs_b;
   logic [XLEN-1:0] rem_next, quo_next, fin_q, fin_r;
   logic            div0, ovf;

   function automatic logic [XLEN-1:0] fmt(input div_op_t op, input logic [XLEN-1:0] q,
                                           input logic [XLEN-1:0] r);
      logic [XLEN-1:0] sel;
      sel = op.is_rem ? r : q;
      return op.is_word ? {{(XLEN-32){sel[31]}}, sel[31:0]} : sel;
   endfunction

   assign in_ready = (state == IDLE);
   assign busy     = (state != IDLE);

   always_comb begin
      ext_a = a_r;
      ext_b = b_r;
      if (op_r.is_word) begin
         ext_a = {{(XLEN-32){op_r.is_signed & a_r[31]}}, a_r[31:0]};
         ext_b = {{(XLEN-32){op_r.is_signed & b_r[31]}}, b_r[31:0]};
      end
      abs_a = (op_r.is_signed && ext_a[XLEN-1]) ? -ext_a : ext_a;
      abs_b = (op_r.is_signed && ext_b[XLEN-1]) ? -ext_b : ext_b;
      div0  = (ext_b == '0);
      ovf   = op_r.is_signed && (ext_b == ONES) && (ext_a == (op_r.is_word ? MIN_W : MIN_D));
   end

   // After PREP, a_r holds the extended dividend, which the special cases return directly.
   always_comb begin
      fin_q = q_neg ? -quo_r : quo_r;
      fin_r = r_neg ? -rem_r : rem_r;
      if (div0_r) begin
         fin_q = ONES;
         fin_r = a_r;
      end else if (ovf_r) begin
         fin_q = a_r;
         fin_r = '0;
      end
   end

   ysyx_22040632_div_step #(.XLEN(XLEN)) u_step (
      .rem      (rem_r),
      .quo      (quo_r),
      .divisor  (b_r),
      .rem_next (rem_next),
      .quo_next (quo_next)
   );

   always_ff @(posedge clk) begin
      if (!rrst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         result    <= '0;
         out_valid <= 1'b0;
         op_r      <= '0;
         a_r       <= '0;
         b_r       <= '0;
         rem_r     <= '0;
         quo_r     <= '0;
         q_neg     <= 1'b0;
         r_neg     <= 1'b0;
         div0_r    <= 1'b0;
         ovf_r     <= 1'b0;
      end else if (flush) begin
         state     <= IDLE;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               op_r  <= div_op;
               a_r   <= src1;
               b_r   <= src2;
               state <= PREP;
            end
            PREP: begin
               a_r    <= ext_a;
               b_r    <= abs_b;
               rem_r  <= '0;
               quo_r  <= op_r.is_word ? (abs_a << WSH) : abs_a;
               cnt    <= op_r.is_word ? CNT_W'(DIV_N32) : CNT_W'(DIV_N64);
               q_neg  <= op_r.is_signed & (ext_a[XLEN-1] ^ ext_b[XLEN-1]);
               r_neg  <= op_r.is_signed & ext_a[XLEN-1];
               div0_r <= div0;
               ovf_r  <= ovf;
`ifdef YSYX_22040632_DIV_EARLY_OUT_EN
               if (div0 || ovf) begin
                  result    <= div0 ? fmt(op_r, ONES, ext_a) : fmt(op_r, ext_a, '0);
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  state <= CALC;
               end
`else
               state  <= CALC;
`endif
            end
            CALC: begin
               rem_r <= rem_next;
               quo_r <= quo_next;
               cnt   <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) state <= FIXUP;
            end
            FIXUP: begin
               result    <= fmt(op_r, fin_q, fin_r);
               out_valid <= 1'b1;
               state     <= DONE;
            end
            DONE: if (out_ready) begin
               out_valid <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_22040632_div_ctrl.sv
// tb/tb_ysyx_22040632_div_ctrl.sv - directed bench for the iterative divider controller
module tb_ysyx_22040632_div_ctrl;
   import ysyx_22040632_riscv_pkg::*;

   logic        clk = 1'b0;
   logic        rrst_n = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   div_op_t     div_op;
   logic [63:0] src1 = '0;
   logic [63:0] src2 = '0;
   logic        busy;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [63:0] result;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   ysyx_22040632_div_ctrl #(.XLEN(64), .CNT_W(7)) dut (
      .clk       (clk),
      .rrst_n    (rrst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .div_op    (div_op),
      .src1      (src1),
      .src2      (src2),
      .busy      (busy),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
      @(negedge clk);
      div_op   = op;
      src1     = a;
      src2     = b;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic wait_out(output int lat);
      lat = 0;
      while (!out_valid && lat < 200) begin
         @(posedge clk);
         #1 lat++;
      end
   endtask

   task automatic release_out(input string tag);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      check({tag, "_idle"}, {63'b0, in_ready}, 64'd1);
   endtask

   task automatic run(input string tag, input logic [2:0] op, input logic [63:0] a,
                      input logic [63:0] b, input logic [63:0] exp, input int exp_lat);
      int lat;
      issue(op, a, b);
      wait_out(lat);
      check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
      check({tag, "_res"}, result, exp);
      release_out(tag);
   endtask

   initial begin
      int lat;
      int seen;
      logic [63:0] held;
      logic stable;

      div_op = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", {63'b0, in_ready}, 64'd1);
      check("rst_busy", {63'b0, busy}, 64'd0);
      check("rst_out_valid", {63'b0, out_valid}, 64'd0);
      check("rst_result", result, 64'd0);
      @(negedge clk);
      rrst_n = 1'b1;

      // op = {is_signed, is_rem, is_word}
      run("divu", 3'b000, 64'd100, 64'd7, 64'd14, 66);
      run("remu", 3'b010, 64'd100, 64'd7, 64'd2, 66);
      run("div_neg", 3'b100, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66);
      run("rem_neg", 3'b110, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66);
      run("rem_negd", 3'b110, 64'd7, -64'sd2, 64'd1, 66);
      run("div_by0", 3'b100, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 66);
      run("remu_by0", 3'b010, 64'd5, 64'd0, 64'd5, 66);
      run("div_ovf", 3'b100, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
          64'h8000_0000_0000_0000, 66);
      run("remw_ovf", 3'b111, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'd0, 34);
      run("divuw", 3'b001, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 34);
      run("divw_neg", 3'b101, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 34);

      // Flush during CALC cycle 10: accept edge, PREP edge, then ten CALC edges.
      issue(3'b000, 64'd100, 64'd7);
      repeat (11) @(posedge clk);
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      check("flush_in_ready", {63'b0, in_ready}, 64'd1);
      check("flush_busy", {63'b0, busy}, 64'd0);
      seen = 0;
      repeat (80) begin
         @(posedge clk);
         #1 if (out_valid) seen++;
      end
      check("flush_no_valid", 64'(seen), 64'd0);
      run("after_flush", 3'b000, 64'd9, 64'd3, 64'd3, 66);

      // Backpressure in DONE.
      issue(3'b000, 64'd1000, 64'd10);
      wait_out(lat);
      check("bp_lat", 64'(lat), 64'd66);
      held = result;
      stable = 1'b1;
      repeat (5) begin
         @(posedge clk);
         #1 if (result !== held || busy !== 1'b1 || out_valid !== 1'b1) stable = 1'b0;
      end
      check("bp_stable", {63'b0, stable}, 64'd1);
      check("bp_result", result, 64'd100);
      release_out("bp");

      // Reset in the middle of an operation.
      issue(3'b100, 64'd50, 64'd5);
      repeat (20) @(posedge clk);
      @(negedge clk);
      rrst_n = 1'b0;
      @(posedge clk);
      #1;
      check("midrst_result", result, 64'd0);
      @(negedge clk);
      rrst_n = 1'b1;
      seen = 0;
      repeat (80) begin
         @(posedge clk);
         #1 if (out_valid) seen++;
      end
      check("midrst_no_valid", 64'(seen), 64'd0);
      check("midrst_in_ready", {63'b0, in_ready}, 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
